// File: rtl/addsub_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
package addsub_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int GROUP_DEF = 4;
  localparam int NGROUP    = WIDTH_DEF / GROUP_DEF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic ovf;
    logic zero;
  } flags_t;

endpackage

// File: rtl/addsub_cla_carry_dist.sv
// One lookahead group on the way down: ripples the group carry-in through the
// group's bit-level g/p terms and forms the sum bits.
module cla_carry_dist
  import addsub_pkg::*;
#(
  parameter int GROUP_W = GROUP_DEF
) (
  input  logic [GROUP_W-1:0] g,
  input  logic [GROUP_W-1:0] p,
  input  logic               c_in,
  output logic [GROUP_W-1:0] sum,
  output logic               c_msb,
  output logic               c_out
);

  // Intra-group carry chain and sum formation.
  always_comb begin
    logic [GROUP_W:0] c_v;
    c_v    = '0;
    c_v[0] = c_in;
    for (int j = 0; j < GROUP_W; j++) begin
      c_v[j+1] = g[j] | (p[j] & c_v[j]);
    end
    sum   = p ^ c_v[GROUP_W-1:0];
    c_msb = c_v[GROUP_W-1];
    c_out = c_v[GROUP_W];
  end

endmodule

// File: rtl/addsub_cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on
// both sides: stage 1 holds bit g/p and group carries, stage 2 holds results.
module addsub_cla_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N_GRP = WIDTH / GROUP;

  logic [WIDTH-1:0] b_eff_s, g_s, p_s, sum_s;
  logic             cin_s;
  logic [N_GRP-1:0] grp_g_s, grp_p_s;
  logic [N_GRP:0]   gc_s;
  logic             en1_s, en2_s, c_top_s;
  flags_t           flags_s;

  logic [WIDTH-1:0] g_r, p_r, result_r;
  logic [N_GRP:0]   gc_r;
  logic             v1_r, v2_r;
  flags_t           flags_r;

  // Operand preparation: subtraction is a + ~b + 1.
  always_comb begin
    cin_s   = op_sub;
    b_eff_s = (op_sub == OP_SUB) ? ~b : b;
    g_s     = a & b_eff_s;
    p_s     = a ^ b_eff_s;
  end

  // Reduce bit g/p to per-group generate and propagate.
  always_comb begin
    logic g_acc;
    logic p_acc;
    grp_g_s = '0;
    grp_p_s = '0;
    g_acc   = 1'b0;
    p_acc   = 1'b1;
    for (int k = 0; k < N_GRP; k++) begin
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        g_acc = g_s[k*GROUP+j] | (p_s[k*GROUP+j] & g_acc);
        p_acc = p_acc & p_s[k*GROUP+j];
      end
      grp_g_s[k] = g_acc;
      grp_p_s[k] = p_acc;
    end
  end

  // Group carry-ins, each expanded independently from cin (two-level lookahead).
  always_comb begin
    logic c_acc;
    gc_s    = '0;
    gc_s[0] = cin_s;
    c_acc   = 1'b0;
    for (int k = 0; k < N_GRP; k++) begin
      c_acc = cin_s;
      for (int j = 0; j <= k; j++) begin
        c_acc = grp_g_s[j] | (grp_p_s[j] & c_acc);
      end
      gc_s[k+1] = c_acc;
    end
  end

  // Pipeline advance enables; a stage loads when empty or when its consumer moves.
  always_comb begin
    en2_s = !v2_r | out_ready;
    en1_s = !v1_r | en2_s;
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r  <= '0;
      p_r  <= '0;
      gc_r <= '0;
      v1_r <= 1'b0;
    end else if (en1_s) begin
      g_r  <= g_s;
      p_r  <= p_s;
      gc_r <= gc_s;
      v1_r <= in_valid;
    end
  end

  for (genvar k = 0; k < N_GRP; k++) begin : g_dist
    if (k == N_GRP - 1) begin : g_top
      logic cout_unused;
      cla_carry_dist #(.GROUP_W(GROUP)) u_dist (
        .g     (g_r[k*GROUP +: GROUP]),
        .p     (p_r[k*GROUP +: GROUP]),
        .c_in  (gc_r[k]),
        .sum   (sum_s[k*GROUP +: GROUP]),
        .c_msb (c_top_s),
        .c_out (cout_unused)
      );
    end else begin : g_low
      logic c_msb_unused;
      logic cout_unused;
      cla_carry_dist #(.GROUP_W(GROUP)) u_dist (
        .g     (g_r[k*GROUP +: GROUP]),
        .p     (p_r[k*GROUP +: GROUP]),
        .c_in  (gc_r[k]),
        .sum   (sum_s[k*GROUP +: GROUP]),
        .c_msb (c_msb_unused),
        .c_out (cout_unused)
      );
    end
  end

  // Flags from the distributed carries and the sum.
  always_comb begin
    flags_s.c_out = gc_r[N_GRP];
    flags_s.ovf   = c_top_s ^ gc_r[N_GRP];
    flags_s.zero  = ~|sum_s;
  end

  // Stage 2 register; holds while the consumer stalls a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= '0;
      flags_r  <= '0;
      v2_r     <= 1'b0;
    end else if (en2_s) begin
      result_r <= sum_s;
      flags_r  <= flags_s;
      v2_r     <= v1_r;
    end
  end

  assign in_ready  = en1_s;
  assign out_valid = v2_r;
  assign result    = result_r;
  assign c_out     = flags_r.c_out;
  assign ovf       = flags_r.ovf;
  assign zero      = flags_r.zero;

endmodule
